// File: rtl/gps_pkg.sv
// rtl/gps_pkg.sv - shared GPS types and constants
// Purpose: receiver state encoding, NMEA character constants and the default
// bit period for the GPS serial line (100 MHz / 9600 baud).
// Ports: none (package).
package gps_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_COMMA  = 8'h2C;

  localparam int DEFAULT_CLKS_PER_BIT = 10417;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous GPS pins
// Purpose: brings an asynchronous input into the clk domain.
// Ports:
//   clk  in  system clock
//   rst  in  synchronous active-high reset; both flops load RST_VAL
//   d    in  asynchronous input
//   q    out synchronized output (second flop)
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gps_uart_rx.sv
// rtl/gps_uart_rx.sv - 8N1 UART receiver for the GPS serial line
// Purpose: samples rxd at mid-bit using a clock-per-bit counter and presents
// each correctly framed byte to the NMEA parser as a one-cycle pulse.
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   rxd         in   asynchronous serial input, idles high
//   uart_data   out  last correctly framed byte, LSB received first
//   uart_valid  out  one-cycle pulse: uart_data holds a new byte
//   frame_err   out  one-cycle pulse: stop bit was low, byte discarded
//   rx_busy     out  high while a frame is in progress
module gps_uart_rx
  import gps_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] uart_data,
  output logic       uart_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic rx_s;

  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  // Cleared by a framing error so a line stuck low (break) yields a single
  // frame_err; set again once rx_s has been seen high in IDLE.
  logic             armed_q, armed_d;

  // Reset value 1 keeps an idle-high line from looking like a start bit.
  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_rxd_sync (
    .clk(clk),
    .rst(rst),
    .d  (rxd),
    .q  (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shreg_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      armed_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      armed_q   <= armed_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    armed_d   = armed_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = START;
        end
      end

      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
          end else begin
            // Low pulse shorter than half a bit: treat as noise.
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d              = '0;
          shreg_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STOP: begin
        // Leaving at mid-stop-bit leaves half a bit to spot a following start.
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
          end else begin
            ferr_d  = 1'b1;
            armed_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign uart_data  = data_q;
  assign uart_valid = valid_q;
  assign frame_err  = ferr_q;
  assign rx_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_gps_uart_rx.sv
// tb/tb_gps_uart_rx.sv - scoreboard bench for gps_uart_rx
module tb_gps_uart_rx;
  import gps_pkg::*;

  localparam int CPB = 16;

  typedef struct {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] uart_data;
  logic       uart_valid;
  logic       frame_err;
  logic       rx_busy;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_fail = 0;
  logic [7:0] mon_last = 8'h00;
  logic       seen_busy;
  logic       seen_pulse;

  always #5 clk = ~clk;

  gps_uart_rx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .uart_data (uart_data),
    .uart_valid(uart_valid),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    rxd = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  // The model: a frame yields its byte if the stop bit is high, else a framing error.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    exp_t e;
    e.err  = !stop_ok;
    e.data = b;
    sb.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
  endtask

  task automatic settle(input string name);
    int k;
    rxd = 1'b1;
    k = 0;
    while (sb.size() != 0 && k < 40 * CPB) begin
      @(negedge clk);
      k++;
    end
    repeat (2 * CPB) @(negedge clk);
    check8({name, "_pending"}, 8'(sb.size()), 8'd0);
    sb.delete();
    check8({name, "_busy"}, {7'd0, rx_busy}, 8'd0);
    check8({name, "_data"}, uart_data, mon_last);
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_last = 8'h00;
      end else begin
        if (rx_busy) seen_busy = 1'b1;
        if (uart_valid || frame_err) begin
          seen_pulse = 1'b1;
          if (uart_valid && frame_err) begin
            check8("valid_err_exclusive", {6'd0, uart_valid, frame_err}, 8'd0);
          end else if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_pulse: got valid=%b err=%b data=%02h expected no pulse",
                     uart_valid, frame_err, uart_data);
          end else begin
            e = sb.pop_front();
            check8("pulse_is_err", {7'd0, frame_err}, {7'd0, e.err});
            if (e.err) begin
              check8("data_held_on_err", uart_data, mon_last);
            end else begin
              check8("rx_byte", uart_data, e.data);
              mon_last = e.data;
            end
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: got no finish expected finish within 5 ms");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] s [7];
    logic [7:0] b;
    logic       ok;
    logic       last_err;

    seen_busy  = 1'b0;
    seen_pulse = 1'b0;

    // 1. Reset with line idle.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check8("reset_data", uart_data, 8'h00);
    check8("reset_valid", {7'd0, uart_valid}, 8'd0);
    check8("reset_err", {7'd0, frame_err}, 8'd0);
    check8("reset_busy", {7'd0, rx_busy}, 8'd0);
    repeat (200) @(negedge clk);
    check8("idle_no_busy", {7'd0, seen_busy}, 8'd0);
    check8("idle_no_pulse", {7'd0, seen_pulse}, 8'd0);

    // 2. Single '$'.
    send_frame(CH_DOLLAR, 1'b1);
    settle("single");

    // 3. "$GPGGA," with no idle time between frames.
    s = '{8'h24, 8'h47, 8'h50, 8'h47, 8'h47, 8'h41, CH_COMMA};
    for (int i = 0; i < 7; i++) send_frame(s[i], 1'b1);
    settle("string");

    // 4. Glitch shorter than half a bit.
    seen_pulse = 1'b0;
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check8("glitch_no_pulse", {7'd0, seen_pulse}, 8'd0);
    settle("glitch");

    // 5. Framing error after a good byte, then recovery.
    send_frame(8'h31, 1'b1);
    send_frame(8'h4E, 1'b0);
    idle_bits(2);
    settle("frame_err");
    send_frame(8'h4E, 1'b1);
    settle("recover");

    // 6. Reset during bit 4 of 8'h33.
    b = 8'h33;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rxd = b[4];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check8("midrst_busy", {7'd0, rx_busy}, 8'd0);
    check8("midrst_data", uart_data, 8'h00);
    check8("midrst_valid", {7'd0, uart_valid}, 8'd0);
    check8("midrst_err", {7'd0, frame_err}, 8'd0);
    rxd = 1'b1;
    rst = 1'b0;
    idle_bits(2);
    settle("midrst");
    send_frame(8'h30, 1'b1);
    settle("after_rst");

    // Random traffic: random bytes, gaps and occasional bad stop bits.
    last_err = 1'b0;
    for (int i = 0; i < 40; i++) begin
      int gap;
      b   = 8'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 7) != 0);
      gap = $urandom_range(0, 2);
      if (last_err && gap == 0) gap = 1;
      if (gap != 0) idle_bits(gap);
      send_frame(b, ok);
      last_err = !ok;
    end
    settle("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
